antares_mdu: RTL

ANTARES_MDU -- requirements
Module: antares_mdu

---
 rtl/antares_mdu_pkg.sv | 39 +++
 rtl/antares_mdu.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/antares_mdu_pkg.sv
// Shared encodings for the Antares multiply/divide unit: operation codes,
// FSM states and small operation-class helpers.
package antares_mdu_pkg;

  typedef enum logic [3:0] {
    OP_MULS  = 4'd0,
    OP_MULU  = 4'd1,
    OP_MADD  = 4'd2,
    OP_MADDU = 4'd3,
    OP_MSUB  = 4'd4,
    OP_MSUBU = 4'd5,
    OP_DIV   = 4'd6,
    OP_DIVU  = 4'd7,
    OP_MTHI  = 4'd8,
    OP_MTLO  = 4'd9,
    OP_NOP   = 4'd15
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MUL   = 2'd1,
    ST_DIV   = 2'd2,
    ST_FINAL = 2'd3
  } mdu_state_e;

  function automatic logic op_is_signed(input mdu_op_e op);
    return (op == OP_MULS) || (op == OP_MADD) || (op == OP_MSUB) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_mul(input mdu_op_e op);
    return (op == OP_MULS) || (op == OP_MULU) || (op == OP_MADD) ||
           (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
  endfunction

  function automatic logic op_is_div(input mdu_op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/antares_mdu.sv
// Iterative multiply/divide unit with HI/LO registers: one bit per cycle on
// operand magnitudes, sign correction and accumulate applied in FINAL.
module antares_mdu
  import antares_mdu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter bit ENABLE_DIV = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            mdu_op,
  input  logic                  mdu_start,
  input  logic [DATA_WIDTH-1:0] mdu_a,
  input  logic [DATA_WIDTH-1:0] mdu_b,
  input  logic                  mdu_stall,
  input  logic                  mdu_flush,
  output logic                  mdu_busy,
  output logic                  mdu_done,
  output logic                  mdu_div_zero,
  output logic [DATA_WIDTH-1:0] mdu_hi,
  output logic [DATA_WIDTH-1:0] mdu_lo
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(W);

  mdu_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  wa_q, wa_d;     // multiply high accumulator / divide remainder
  logic [W-1:0]  wb_q, wb_d;     // multiplier then product low / dividend then quotient
  logic [W-1:0]  opnd_q, opnd_d; // multiplicand or divisor magnitude
  mdu_op_e       op_q, op_d;
  logic          neg_res_q, neg_res_d;
  logic          neg_rem_q, neg_rem_d;
  logic [W-1:0]  hi_q, hi_d, lo_q, lo_d;
  logic          busy_q, busy_d, done_q, done_d, dz_q, dz_d;

  mdu_op_e       op_in;
  logic          accept, a_neg, b_neg;
  logic [W-1:0]  a_mag, b_mag;
  logic [W:0]    mul_sum, div_shl;
  logic          div_ge;
  logic [2*W-1:0] prod, prod_s;

  always_comb begin
    op_in  = mdu_op_e'(mdu_op);
    accept = mdu_start & ~mdu_stall & ~mdu_flush & (state_q == ST_IDLE);
    a_neg  = op_is_signed(op_in) & mdu_a[W-1];
    b_neg  = op_is_signed(op_in) & mdu_b[W-1];
    a_mag  = a_neg ? -mdu_a : mdu_a;
    b_mag  = b_neg ? -mdu_b : mdu_b;

    mul_sum = {1'b0, wa_q} + {1'b0, (wb_q[0] ? opnd_q : {W{1'b0}})};
    div_shl = {wa_q, wb_q[W-1]};
    div_ge  = div_shl >= {1'b0, opnd_q};
    prod    = {wa_q, wb_q};
    prod_s  = neg_res_q ? -prod : prod;

    state_d   = state_q;
    cnt_d     = cnt_q;
    wa_d      = wa_q;
    wb_d      = wb_q;
    opnd_d    = opnd_q;
    op_d      = op_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dz_d      = dz_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d      = op_in;
          cnt_d     = '0;
          wa_d      = '0;
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          if (op_is_mul(op_in)) begin
            state_d = ST_MUL;
            wb_d    = b_mag;
            opnd_d  = a_mag;
          end else if (op_is_div(op_in)) begin
            if (!ENABLE_DIV || (mdu_b == '0)) begin
              done_d = 1'b1;
              dz_d   = 1'b1;
            end else begin
              state_d = ST_DIV;
              wb_d    = a_mag;
              opnd_d  = b_mag;
            end
          end else if (op_in == OP_MTHI) begin
            hi_d = mdu_a;
          end else if (op_in == OP_MTLO) begin
            lo_d = mdu_a;
          end
        end
      end
      // One spare counted cycle after the W iterations gives the W+2 edge latency.
      ST_MUL, ST_DIV: begin
        if (mdu_flush) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_FINAL;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (state_q == ST_MUL) begin
            wa_d = mul_sum[W:1];
            wb_d = {mul_sum[0], wb_q[W-1:1]};
          end else begin
            wa_d = div_ge ? W'(div_shl - {1'b0, opnd_q}) : div_shl[W-1:0];
            wb_d = {wb_q[W-2:0], div_ge};
          end
        end
      end
      ST_FINAL: begin
        state_d = ST_IDLE;
        if (!mdu_flush) begin
          done_d = 1'b1;
          dz_d   = 1'b0;
          case (op_q)
            OP_MADD, OP_MADDU: {hi_d, lo_d} = {hi_q, lo_q} + prod_s;
            OP_MSUB, OP_MSUBU: {hi_d, lo_d} = {hi_q, lo_q} - prod_s;
            OP_DIV, OP_DIVU: begin
              lo_d = neg_res_q ? -wb_q : wb_q;
              hi_d = neg_rem_q ? -wa_q : wa_q;
            end
            default: {hi_d, lo_d} = prod_s;
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  // Iteration datapath carries no reset; it is reloaded on every acceptance.
  always_ff @(posedge clk) begin
    cnt_q     <= cnt_d;
    wa_q      <= wa_d;
    wb_q      <= wb_d;
    opnd_q    <= opnd_d;
    op_q      <= op_d;
    neg_res_q <= neg_res_d;
    neg_rem_q <= neg_rem_d;
  end

  assign mdu_busy     = busy_q;
  assign mdu_done     = done_q;
  assign mdu_div_zero = dz_q;
  assign mdu_hi       = hi_q;
  assign mdu_lo       = lo_q;

endmodule
